// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types and constants: NOP encoding, reset defaults, opcode map.
// Pure declarations, no logic, so no latency.
// No flow control of its own.
package if_fetch_stage_pkg;
  localparam logic [31:0] NOP           = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam int          BUF_DEPTH_DEF = 2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misalign;
  } buf_entry_t;

  localparam int ENTRY_W = $bits(buf_entry_t);
endpackage

// File: rtl/if_fetch_stage_buf.sv
// Instruction buffer: DEPTH-entry circular FIFO of {instr, pc, misalign} with flush.
// Write visible at head the cycle after; head is a registered entry.
// No internal backpressure: the caller never writes when full or pops when empty.
module if_fetch_stage_buf
  import if_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_dat,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] head,
  output logic [CNT_W-1:0]   count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A write in the flush cycle becomes the sole entry (used for the halt marker).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= wr_en ? nxt('0) : '0;
      count  <= wr_en ? CNT_W'(1) : '0;
      if (wr_en) mem[0] <= wr_dat;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (rd_en) rd_ptr <= nxt(rd_ptr);
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns PC, issues in-order imem requests, buffers words for decode. Optional IF_MISALIGN_CHK_EN.
// Latency: issue -> rvalid (memory) -> id_valid next cycle; redirect at N gives req at N+1.
// Backpressure: id_stall holds head; issue stops once in-flight + buffered reaches BUF_DEPTH.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_func3,
  output logic        id_func7
`ifdef IF_MISALIGN_CHK_EN
  , output logic      id_misalign
`endif
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [31:0]      pc, resp_pc, redir_pc;
  logic             run, halted, redir_mis;
  logic [CNT_W-1:0] inflight, inflight_nxt, drop, buf_count;
  logic [CNT_W:0]   occ;
  logic             pop, issue, keep;
  buf_entry_t       wr_dat, head;

`ifdef IF_MISALIGN_CHK_EN
  assign redir_pc  = redirect_pc;
  assign redir_mis = |redirect_pc[1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              halted <= 1'b0;
    else if (redirect_valid) halted <= redir_mis;
  end
  assign id_misalign = id_valid & head.misalign;
`else
  assign redir_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign redir_mis = 1'b0;
  assign halted    = 1'b0;
`endif

  // A halt marker at the head is never consumed; only a redirect removes it.
  assign pop   = id_valid & ~id_stall & ~head.misalign;
  // Counting this cycle's pop keeps one-per-cycle throughput without risking overflow.
  assign occ   = {1'b0, inflight} + {1'b0, buf_count} - (CNT_W + 1)'(pop);
  assign imem_req  = run & ~redirect_valid & ~halted & (occ < (CNT_W + 1)'(BUF_DEPTH));
  assign imem_addr = pc;
  assign issue = imem_req & imem_ready;
  assign keep  = imem_rvalid & (drop == '0) & ~redirect_valid;
  assign inflight_nxt = inflight + CNT_W'(issue) - CNT_W'(imem_rvalid);

  always_comb begin
    wr_dat = '{instr: imem_rdata, pc: resp_pc, misalign: 1'b0};
    if (redirect_valid) wr_dat = '{instr: NOP, pc: redir_pc, misalign: 1'b1};
  end

  // resp_pc tracks the PC of the next response that will actually be kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        pc      <= redir_pc;
        resp_pc <= redir_pc;
        drop    <= inflight_nxt;
      end else begin
        if (issue) pc <= pc + 32'd4;
        if (keep) resp_pc <= resp_pc + 32'd4;
        if (imem_rvalid && drop != '0) drop <= drop - 1'b1;
      end
    end
  end

  if_fetch_stage_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (redirect_valid),
    .wr_en  (redirect_valid ? redir_mis : keep),
    .wr_dat (wr_dat),
    .rd_en  (pop),
    .head   (head),
    .count  (buf_count)
  );

  assign id_valid  = (buf_count != '0);
  assign id_instr  = id_valid ? head.instr : NOP;
  assign id_pc     = id_valid ? head.pc : 32'd0;
  assign id_pc4    = id_pc + 32'd4;
  assign id_opcode = id_instr[6:0];
  assign id_func3  = id_instr[14:12];
  assign id_func7  = id_instr[30];
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: in-order memory model with programmable latency/ready,
// vector table for start-up and stall, directed redirect sequences, random scoreboard run.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, id_stall;
  logic [31:0] redirect_pc;
  logic        id_valid, id_func7;
  logic [31:0] id_instr, id_pc, id_pc4;
  logic [6:0]  id_opcode;
  logic [2:0]  id_func3;
`ifdef IF_MISALIGN_CHK_EN
  logic        id_misalign;
`endif

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4),
    .id_opcode(id_opcode), .id_func3(id_func3), .id_func7(id_func7)
`ifdef IF_MISALIGN_CHK_EN
    , .id_misalign(id_misalign)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mem_lat = 1;
  bit rnd_mem = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0193) ^ 32'h5A5A_A5A3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive_mem();
    imem_ready = rnd_mem ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  endtask

  // Drive memory for this cycle, then sample at negedge and log any issued request.
  task automatic step();
    drive_mem();
    @(negedge clk);
    if (rst_n && imem_req && imem_ready) begin
      q_addr.push_back(imem_addr);
      q_due.push_back(cyc + mem_lat + (rnd_mem ? int'($urandom_range(0, 2)) : 0));
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic restart(input int lat, input bit rnd);
    rst_n = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    q_addr.delete(); q_due.delete();
    mem_lat = lat; rnd_mem = rnd;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, ".req"},   32'(imem_req), 32'd0);
    chk({nm, ".vld"},   32'(id_valid), 32'd0);
    chk({nm, ".instr"}, id_instr, NOP_I);
    chk({nm, ".pc"},    id_pc, 32'd0);
    chk({nm, ".pc4"},   id_pc4, 32'd4);
`ifdef IF_MISALIGN_CHK_EN
    chk({nm, ".mis"},   32'(id_misalign), 32'd0);
`endif
  endtask

  task automatic check_out(input string nm, input logic e_req, input logic [31:0] e_addr,
                           input logic e_vld, input logic [31:0] e_pc);
    logic [31:0] e_ins;
    e_ins = e_vld ? mem_word(e_pc) : NOP_I;
    chk({nm, ".req"}, 32'(imem_req), 32'(e_req));
    if (e_req) chk({nm, ".addr"}, imem_addr, e_addr);
    chk({nm, ".vld"},   32'(id_valid), 32'(e_vld));
    chk({nm, ".instr"}, id_instr, e_ins);
    if (e_vld) begin
      chk({nm, ".pc"},  id_pc, e_pc);
      chk({nm, ".pc4"}, id_pc4, e_pc + 32'd4);
      chk({nm, ".fld"}, {21'd0, id_func7, id_func3, id_opcode},
          {21'd0, e_ins[30], e_ins[14:12], e_ins[6:0]});
    end
  endtask

  typedef struct {
    logic        stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops;
    logic [31:0] exp_pc;

    // Start-up with always-ready 1-cycle memory, then a 5-cycle stall at cycles 9..13.
    tbl[0]  = '{0, 0, 32'h00, 0, 32'h00};
    tbl[1]  = '{0, 1, 32'h00, 0, 32'h00};
    tbl[2]  = '{0, 1, 32'h04, 0, 32'h00};
    tbl[3]  = '{0, 1, 32'h08, 1, 32'h00};
    tbl[4]  = '{0, 1, 32'h0C, 1, 32'h04};
    tbl[5]  = '{0, 1, 32'h10, 1, 32'h08};
    tbl[6]  = '{0, 1, 32'h14, 1, 32'h0C};
    tbl[7]  = '{0, 1, 32'h18, 1, 32'h10};
    tbl[8]  = '{0, 1, 32'h1C, 1, 32'h14};
    for (int i = 9; i <= 13; i++) tbl[i] = '{1, 0, 32'h20, 1, 32'h18};
    tbl[14] = '{0, 1, 32'h20, 1, 32'h18};
    tbl[15] = '{0, 1, 32'h24, 1, 32'h1C};
    tbl[16] = '{0, 1, 32'h28, 1, 32'h20};
    tbl[17] = '{0, 1, 32'h2C, 1, 32'h24};

    rst_n = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");

    restart(1, 0);
    for (int i = 0; i < 18; i++) begin
      id_stall = tbl[i].stall;
      step();
      check_out($sformatf("tbl%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_pc);
      adv();
    end
    id_stall = 1'b0;

    // Asynchronous reset in the middle of traffic.
    rst_n = 1'b0;
    #1;
    check_reset("midrst");

    // 3-cycle memory: redirect to 0x100 with two requests in flight.
    restart(3, 0);
    for (int c = 0; c <= 9; c++) begin
      logic er, ev;
      logic [31:0] ea;
      redirect_valid = (c == 3);
      redirect_pc    = 32'h100;
      er = 1'b0; ea = '0; ev = 1'b0;
      case (c)
        1: begin er = 1'b1; ea = 32'h000; end
        2: begin er = 1'b1; ea = 32'h004; end
        5: begin er = 1'b1; ea = 32'h100; end
        6: begin er = 1'b1; ea = 32'h104; end
        9: begin er = 1'b1; ea = 32'h108; ev = 1'b1; end
        default: ;
      endcase
      step();
      check_out($sformatf("redir%0d", c), er, ea, ev, 32'h100);
      adv();
    end
    redirect_valid = 1'b0;

    // Redirect while stalled with a response landing in the same cycle.
    restart(1, 0);
    for (int c = 0; c <= 8; c++) begin
      logic er, ev;
      logic [31:0] ea, ep;
      id_stall       = (c == 5);
      redirect_valid = (c == 5);
      redirect_pc    = 32'h200;
      er = 1'b1; ev = 1'b0; ea = '0; ep = '0;
      case (c)
        0: er = 1'b0;
        1: ea = 32'h000;
        2: ea = 32'h004;
        3: begin ea = 32'h008; ev = 1'b1; ep = 32'h000; end
        4: begin ea = 32'h00C; ev = 1'b1; ep = 32'h004; end
        5: begin er = 1'b0; ev = 1'b1; ep = 32'h008; end
        6: ea = 32'h200;
        7: ea = 32'h204;
        default: begin ea = 32'h208; ev = 1'b1; ep = 32'h200; end
      endcase
      step();
      check_out($sformatf("stred%0d", c), er, ea, ev, ep);
      adv();
    end
    id_stall = 1'b0;

    // Misaligned redirect target 0x102.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    check_out("mis_redir", 1'b0, 32'h0, 1'b1, 32'h204);
    adv();
    redirect_valid = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
    for (int c = 10; c <= 13; c++) begin
      step();
      chk($sformatf("halt%0d.req", c), 32'(imem_req), 32'd0);
      chk($sformatf("halt%0d.vld", c), 32'(id_valid), 32'd1);
      chk($sformatf("halt%0d.mis", c), 32'(id_misalign), 32'd1);
      chk($sformatf("halt%0d.pc", c), id_pc, 32'h102);
      chk($sformatf("halt%0d.instr", c), id_instr, NOP_I);
      adv();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    chk("unhalt.req", 32'(imem_req), 32'd0);
    adv();
    redirect_valid = 1'b0;
    step();
    check_out("unhalt1", 1'b1, 32'h200, 1'b0, 32'h0);
    chk("unhalt1.mis", 32'(id_misalign), 32'd0);
    adv();
    step();
    check_out("unhalt2", 1'b1, 32'h204, 1'b0, 32'h0);
    adv();
    step();
    check_out("unhalt3", 1'b1, 32'h208, 1'b1, 32'h200);
    chk("unhalt3.mis", 32'(id_misalign), 32'd0);
    adv();
`else
    step();
    check_out("align1", 1'b1, 32'h100, 1'b0, 32'h0);
    adv();
    step();
    check_out("align2", 1'b1, 32'h104, 1'b0, 32'h0);
    adv();
    step();
    check_out("align3", 1'b1, 32'h108, 1'b1, 32'h100);
    adv();
`endif

    // Random ready/latency/stall/redirect with a PC-sequence scoreboard.
    restart(1, 1);
    exp_pc = 32'h0;
    pops   = 0;
    for (int k = 0; k < 20000 && pops < 1000; k++) begin
      id_stall       = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 59) == 0);
      redirect_pc    = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      step();
      if (redirect_valid) begin
        exp_pc = redirect_pc;
      end else if (id_valid && !id_stall) begin
        chk("sb_pc", id_pc, exp_pc);
        chk("sb_instr", id_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      adv();
    end
    redirect_valid = 1'b0;
    id_stall       = 1'b0;
    chk("sb_done", 32'(pops >= 1000), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
